cp0_ctrl: RTL and testbench

- Parametrised coprocessor-0 control block, the successor of the basic CP0 register file.
- Holds Count, Compare, Status, Cause, EPC and BadVAddr, and generates the precise-interrupt request.
- Commits exceptions and ERET from the memory/commit stage, and produces a registered redirect (target PC plus flush) for the fetch unit.
- Sits beside the commit stage; MFC0 reads come from the execute stage.

---
 rtl/cp0_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cp0_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 control block. Holds Count, Compare, Status, Cause,
// EPC and BadVAddr, generates the interrupt request, commits exceptions/ERET
// and produces a registered redirect for fetch.
// Optional build macro: CP0_TIMER_INT_EN enables Compare and the timer interrupt.
module cp0_ctrl #(
  parameter int          HW_INT_N   = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
  parameter logic [31:0] STATUS_RST = 32'h00400000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  output logic [31:0]         rdata,
  input  logic [HW_INT_N-1:0] int_i,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_bd,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  output logic                int_req_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic                redirect_o,
  output logic [31:0]         redirect_pc_o
);

  localparam logic [4:0] R_BADVADDR = 5'd8;
  localparam logic [4:0] R_COUNT    = 5'd9;
  localparam logic [4:0] R_COMPARE  = 5'd11;
  localparam logic [4:0] R_STATUS   = 5'd12;
  localparam logic [4:0] R_CAUSE    = 5'd13;
  localparam logic [4:0] R_EPC      = 5'd14;
  localparam logic [4:0] R_PRID     = 5'd15;
  localparam logic [4:0] R_CONFIG   = 5'd16;
  localparam logic [1:0] PRESC_TOP  = 2'(COUNT_DIV - 1);

  logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d, redirect_pc_q, redirect_pc_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d, presc_q, presc_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        ti_q, ti_d, bd_q, bd_d, redirect_q, redirect_d;
  logic [7:0]  ip;
  logic [31:0] cause;

  // Timer interrupt shares IP[7] with the top hardware line.
  assign ip        = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
  assign cause     = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};
  assign int_req_o = status_q[0] & ~status_q[1] & |(ip & status_q[15:8]);
  assign status_o  = status_q;
  assign cause_o   = cause;
  assign epc_o     = epc_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

  // MFC0 read mux: current register contents, no write bypass.
  always_comb begin
    rdata = '0;
    case (raddr)
      R_BADVADDR: rdata = badvaddr_q;
      R_COUNT:    rdata = count_q;
      R_COMPARE:  rdata = compare_q;
      R_STATUS:   rdata = status_q;
      R_CAUSE:    rdata = cause;
      R_EPC:      rdata = epc_q;
      R_PRID:     rdata = 32'h004C0102;
      R_CONFIG:   rdata = 32'h00008000;
      default:    rdata = '0;
    endcase
  end

  // Next state: counter, MTC0, then exception/ERET overriding the fields they own.
  always_comb begin
    count_d       = count_q;
    compare_d     = compare_q;
    status_d      = status_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    ip_hw_d       = ip_hw_q;
    ip_sw_d       = ip_sw_q;
    presc_d       = presc_q;
    exccode_d     = exccode_q;
    ti_d          = ti_q;
    bd_d          = bd_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (!stall) begin
      if (presc_q == PRESC_TOP) begin
        presc_d = '0;
        count_d = count_q + 32'd1;
      end else begin
        presc_d = presc_q + 2'd1;
      end
      ip_hw_d = '0;
      ip_hw_d[HW_INT_N-1:0] = int_i;
`ifdef CP0_TIMER_INT_EN
      if (count_q == compare_q && !(we && waddr == R_COUNT)) ti_d = 1'b1;
`endif
      if (we) begin
        case (waddr)
          R_COUNT:  count_d  = wdata;
`ifdef CP0_TIMER_INT_EN
          R_COMPARE: begin
            compare_d = wdata;
            ti_d      = 1'b0;
          end
`endif
          R_STATUS: status_d = wdata;
          R_CAUSE:  ip_sw_d  = wdata[9:8];
          R_EPC:    epc_d    = wdata;
          default:  ;
        endcase
      end
      if (exc_valid) begin
        if (!status_q[1]) begin
          epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
          bd_d  = exc_bd;
        end
        status_d[1] = 1'b1;
        exccode_d   = exc_code;
        if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr_d = exc_badvaddr;
        redirect_d    = 1'b1;
        redirect_pc_d = EXC_VEC;
      end else if (eret) begin
        status_d[1]   = 1'b0;
        redirect_d    = 1'b1;
        redirect_pc_d = epc_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      compare_q     <= '0;
      status_q      <= STATUS_RST;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      ip_hw_q       <= '0;
      ip_sw_q       <= '0;
      presc_q       <= '0;
      exccode_q     <= '0;
      ti_q          <= 1'b0;
      bd_q          <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      count_q       <= count_d;
      compare_q     <= compare_d;
      status_q      <= status_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      ip_hw_q       <= ip_hw_d;
      ip_sw_q       <= ip_sw_d;
      presc_q       <= presc_d;
      exccode_q     <= exccode_d;
      ti_q          <= ti_d;
      bd_q          <= bd_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed vectors with hand-computed expectations for cp0_ctrl.
module tb_cp0_ctrl;
  logic        clk = 1'b0;
  logic        rst, stall, we, exc_valid, exc_bd, eret;
  logic [4:0]  waddr, raddr, exc_code;
  logic [31:0] wdata, exc_pc, exc_badvaddr;
  logic [5:0]  int_i;
  logic [31:0] rdata, status_o, cause_o, epc_o, redirect_pc_o;
  logic        int_req_o, redirect_o;
  int          errs = 0;
  int          nchk = 0;

  cp0_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .int_i(int_i), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .int_req_o(int_req_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; exc_valid = 0; eret = 0; stall = 0;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst = 1; stall = 0; we = 0; waddr = 0; wdata = 0; raddr = 0; int_i = 0;
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badvaddr = 0; eret = 0;
    step(); step();
    // reset state
    chk("rst_status", status_o, 32'h00400000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_redir", {31'b0, redirect_o}, 32'h0);
    chk("rst_redir_pc", redirect_pc_o, 32'h0);
    chk("rst_intreq", {31'b0, int_req_o}, 32'h0);
    rd(5'd9, "rst_count", 32'h0);
    rd(5'd15, "prid", 32'h004C0102);
    rd(5'd16, "config", 32'h00008000);
    rd(5'd3, "unmapped", 32'h0);

    // Count with divide-by-2, then hold under stall
    rst = 0;
    repeat (4) step();
    rd(5'd9, "count_4cyc", 32'd2);
    stall = 1;
    repeat (3) step();
    rd(5'd9, "count_stall", 32'd2);
    stall = 0;

`ifdef CP0_TIMER_INT_EN
    begin
      int n;
      we = 1; waddr = 5'd11; wdata = 32'd10; step();
      waddr = 5'd9; wdata = 32'd0; step();
      we = 0;
      chk("ti_clear", {31'b0, cause_o[30]}, 32'h0);
      n = 0;
      while (!cause_o[30] && n < 30) begin step(); n++; end
      chk("ti_set", {31'b0, cause_o[30]}, 32'h1);
      chk("ti_window", {31'b0, (n >= 17 && n <= 21)}, 32'h1);
      we = 1; waddr = 5'd12; wdata = 32'h00008001; step();
      we = 0;
      chk("ti_intreq", {31'b0, int_req_o}, 32'h1);
      we = 1; waddr = 5'd11; wdata = 32'd10; step();
      we = 0;
      chk("ti_cmp_clr", {31'b0, cause_o[30]}, 32'h0);
      rst = 1; step(); rst = 0;
    end
`else
    we = 1; waddr = 5'd11; wdata = 32'd5; step();
    we = 0;
    rd(5'd11, "compare_off", 32'h0);
    chk("ti_off", {31'b0, cause_o[30]}, 32'h0);
`endif

    // delay-slot address-error exception
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'hBFC00104; exc_bd = 1; exc_badvaddr = 32'h3;
    step();
    idle();
    chk("ds_epc", epc_o, 32'hBFC00100);
    chk("ds_bd", {31'b0, cause_o[31]}, 32'h1);
    chk("ds_code", {27'b0, cause_o[6:2]}, 32'd4);
    chk("ds_exl", {31'b0, status_o[1]}, 32'h1);
    chk("ds_redir", {31'b0, redirect_o}, 32'h1);
    chk("ds_redir_pc", redirect_pc_o, 32'hBFC00380);
    rd(5'd8, "ds_badva", 32'h3);
    step();
    chk("ds_pulse", {31'b0, redirect_o}, 32'h0);

    // nested exception keeps EPC/BD
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h80000010; exc_bd = 0; exc_badvaddr = 32'hDEAD;
    step();
    idle();
    chk("nest_epc", epc_o, 32'hBFC00100);
    chk("nest_cause", cause_o, 32'h80000020);
    rd(5'd8, "nest_badva", 32'h3);

    // ERET redirects to EPC
    we = 1; waddr = 5'd14; wdata = 32'h80001000; step();
    we = 0;
    rd(5'd14, "mtc0_epc", 32'h80001000);
    eret = 1; step();
    eret = 0;
    chk("eret_status", status_o, 32'h00400000);
    chk("eret_redir", {31'b0, redirect_o}, 32'h1);
    chk("eret_pc", redirect_pc_o, 32'h80001000);
    step();
    chk("eret_pulse", {31'b0, redirect_o}, 32'h0);

    // exception beats same-cycle MTC0 to EPC
    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h400; exc_bd = 0;
    we = 1; waddr = 5'd14; wdata = 32'h1234;
    step();
    idle();
    chk("conf_epc", epc_o, 32'h400);
    step();
    // exception under stall is ignored
    stall = 1; exc_valid = 1; exc_code = 5'd10; exc_pc = 32'h500;
    step();
    idle();
    chk("stall_epc", epc_o, 32'h400);
    chk("stall_cause", cause_o, 32'h00000030);
    chk("stall_redir", {31'b0, redirect_o}, 32'h0);

    // interrupt gated by EXL, released by ERET
    int_i = 6'b000100;
    we = 1; waddr = 5'd12; wdata = 32'h00001003; step();
    we = 0;
    chk("gate_cause", cause_o, 32'h00001030);
    chk("gate_intreq", {31'b0, int_req_o}, 32'h0);
    eret = 1; step();
    eret = 0;
    chk("open_status", status_o, 32'h00001001);
    chk("open_intreq", {31'b0, int_req_o}, 32'h1);
    chk("open_pc", redirect_pc_o, 32'h400);

    // Cause: only software IP bits are writable
    we = 1; waddr = 5'd13; wdata = 32'hFFFFFFFF; step();
    we = 0;
    chk("cause_sw", cause_o, 32'h00001330);

    // mid-operation reset
    rst = 1; step(); rst = 0;
    chk("mrst_status", status_o, 32'h00400000);
    chk("mrst_cause", cause_o, 32'h0);
    chk("mrst_epc", epc_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
